// File: rtl/led_display_package.sv
// Panel geometry and the row bit-plane type shared by the LED frame scheduler.
package led_display_package;
    localparam int NUM_ROWS     = 32;
    localparam int NUM_COLS     = 64;
    localparam int COLOUR_DEPTH = 8;

    // One bit-plane of a top/bottom row pair; each pixel is {r, g, b}.
    typedef struct packed {
        logic [NUM_COLS-1:0][2:0] top;
        logic [NUM_COLS-1:0][2:0] bot;
    } rgb_row_t;

    // Counter width able to hold the longest window, oe_unit << (depth-1).
    function automatic int oe_count_width(input int oe_unit, input int depth);
        return $clog2((oe_unit << (depth - 1)) + 1);
    endfunction
endpackage

// File: rtl/led_display_oe_timer.sv
// Output-enable window: down-counter loaded on accept, busy while non-zero.
module led_display_oe_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk_in,
    input  logic             n_reset_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_value_in,
    output logic             busy_out
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_value_in;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_out = (count_q != '0);
endmodule

// File: rtl/led_display_frame_scheduler.sv
// Scans frame RAM row-pair by bit-plane, hands each plane to the panel driver
// and times its binary-weighted output-enable window.
//
// state   | meaning
// IDLE    | stopped, waiting for enable_in
// FETCH   | 128 RAM reads (top/bottom per column) plus one capture cycle
// PRESENT | row_out valid, waiting for the driver to accept
// WAIT_OE | row fetched (or stop requested), waiting for the OE window to end
module led_display_frame_scheduler #(
    parameter int NUM_ROWS     = led_display_package::NUM_ROWS,
    parameter int NUM_COLS     = led_display_package::NUM_COLS,
    parameter int COLOUR_DEPTH = led_display_package::COLOUR_DEPTH,
    parameter int OE_UNIT      = 4
) (
    input  logic                                       clk_in,
    input  logic                                       n_reset_in,
    input  logic                                       enable_in,
    output logic                                       ram_enable_out,
    output logic [$clog2(NUM_ROWS)+$clog2(NUM_COLS)-1:0] ram_addr_out,
    input  logic [3*COLOUR_DEPTH-1:0]                  ram_data_in,
    output led_display_package::rgb_row_t              row_out,
    output logic                                       row_valid_out,
    input  logic                                       row_ready_in,
    output logic [$clog2(NUM_ROWS/2)-1:0]              row_address_out,
    output logic                                       oe_window_out,
    output logic                                       frame_done_out
);
    localparam int RA_W  = $clog2(NUM_ROWS / 2);
    localparam int PL_W  = $clog2(COLOUR_DEPTH);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int READS = 2 * NUM_COLS;
    localparam int CNT_W = $clog2(READS + 1);
    localparam int CAP_W = COL_W + 1;
    localparam int OE_W  = led_display_package::oe_count_width(OE_UNIT, COLOUR_DEPTH);

    localparam logic [OE_W-1:0] OE_BASE = OE_W'(OE_UNIT);
    localparam logic [RA_W-1:0] LAST_R  = RA_W'(NUM_ROWS / 2 - 1);
    localparam logic [PL_W-1:0] LAST_P  = PL_W'(COLOUR_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, WAIT_OE} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [RA_W-1:0]               r_q, r_d;
    logic [PL_W-1:0]               p_q, p_d;
    logic                          stop_q, stop_d;
    logic [RA_W-1:0]               row_addr_q, row_addr_d;
    logic                          frame_done_q, frame_done_d;
    led_display_package::rgb_row_t row_q, row_d;

    logic                          oe_load;
    logic [OE_W-1:0]               oe_load_val;
    logic                          oe_busy;
    logic [CAP_W-1:0]              cap_idx;
    logic [COL_W-1:0]              cap_col;
    logic [2:0]                    cap_pix;
    logic [COLOUR_DEPTH-1:0]       ch_r, ch_g, ch_b;

    // Read cnt_q returns its data while cnt_q+1 is being issued.
    assign cap_idx = cnt_q[COL_W:0] - CAP_W'(1);
    assign cap_col = cap_idx[COL_W:1];
    assign ch_r    = ram_data_in[3*COLOUR_DEPTH-1:2*COLOUR_DEPTH];
    assign ch_g    = ram_data_in[2*COLOUR_DEPTH-1:COLOUR_DEPTH];
    assign ch_b    = ram_data_in[COLOUR_DEPTH-1:0];
    assign cap_pix = {ch_r[p_q], ch_g[p_q], ch_b[p_q]};

    assign ram_enable_out  = (state_q == FETCH) && (cnt_q < CNT_W'(READS));
    assign ram_addr_out    = ram_enable_out ? {cnt_q[0], r_q, cnt_q[COL_W:1]} : '0;
    assign row_out         = row_q;
    assign row_valid_out   = (state_q == PRESENT);
    assign row_address_out = row_addr_q;
    assign frame_done_out  = frame_done_q;
    assign oe_window_out   = oe_busy;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        r_d          = r_q;
        p_d          = p_q;
        stop_d       = stop_q;
        row_addr_d   = row_addr_q;
        frame_done_d = 1'b0;
        row_d        = row_q;
        oe_load      = 1'b0;
        oe_load_val  = OE_BASE << p_q;
        unique case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                    r_d     = '0;
                    p_d     = '0;
                    stop_d  = 1'b0;
                end
            end
            FETCH: begin
                if (cnt_q != '0) begin
                    if (cap_idx[0]) row_d.bot[cap_col] = cap_pix;
                    else            row_d.top[cap_col] = cap_pix;
                end
                if (cnt_q == CNT_W'(READS)) begin
                    cnt_d   = '0;
                    state_d = oe_busy ? WAIT_OE : PRESENT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (row_ready_in) begin
                    oe_load      = 1'b1;
                    row_addr_d   = r_q;
                    frame_done_d = (r_q == LAST_R) && (p_q == LAST_P);
                    if (enable_in) begin
                        state_d = FETCH;
                        if (p_q == LAST_P) begin
                            p_d = '0;
                            r_d = (r_q == LAST_R) ? '0 : r_q + RA_W'(1);
                        end else begin
                            p_d = p_q + PL_W'(1);
                        end
                    end else begin
                        // Stop after this window; the next run starts from the top.
                        state_d = WAIT_OE;
                        stop_d  = 1'b1;
                        r_d     = '0;
                        p_d     = '0;
                    end
                end
            end
            WAIT_OE: begin
                if (!oe_busy) state_d = stop_q ? IDLE : PRESENT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            r_q          <= '0;
            p_q          <= '0;
            stop_q       <= 1'b0;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
            row_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            r_q          <= r_d;
            p_q          <= p_d;
            stop_q       <= stop_d;
            row_addr_q   <= row_addr_d;
            frame_done_q <= frame_done_d;
            row_q        <= row_d;
        end
    end

    led_display_oe_timer #(.WIDTH(OE_W)) u_oe_timer (
        .clk_in        (clk_in),
        .n_reset_in    (n_reset_in),
        .load_in       (oe_load),
        .load_value_in (oe_load_val),
        .busy_out      (oe_busy)
    );
endmodule

// File: tb/tb_led_display_frame_scheduler.sv
// Scoreboard bench for the LED frame scheduler: a frame-level model predicts
// every accepted row plane, its OE width and the RAM read sequence.
module tb_led_display_frame_scheduler;
    import led_display_package::*;

    localparam int OE_UNIT   = 4;
    localparam int ROW_ADDRS = NUM_ROWS / 2;

    logic        clk_in = 1'b0;
    logic        n_reset_in = 1'b1;
    logic        enable_in = 1'b0;
    logic        row_ready_in = 1'b0;
    logic        ram_enable_out;
    logic [10:0] ram_addr_out;
    logic [23:0] ram_data_in;
    rgb_row_t    row_out;
    logic        row_valid_out;
    logic [3:0]  row_address_out;
    logic        oe_window_out;
    logic        frame_done_out;

    led_display_frame_scheduler #(.OE_UNIT(OE_UNIT)) dut (
        .clk_in          (clk_in),
        .n_reset_in      (n_reset_in),
        .enable_in       (enable_in),
        .ram_enable_out  (ram_enable_out),
        .ram_addr_out    (ram_addr_out),
        .ram_data_in     (ram_data_in),
        .row_out         (row_out),
        .row_valid_out   (row_valid_out),
        .row_ready_in    (row_ready_in),
        .row_address_out (row_address_out),
        .oe_window_out   (oe_window_out),
        .frame_done_out  (frame_done_out)
    );

    always #25 clk_in = ~clk_in;

    logic [23:0] mem [0:2047];
    always @(posedge clk_in) if (ram_enable_out) ram_data_in <= mem[ram_addr_out];

    typedef struct {
        int       r;
        int       p;
        rgb_row_t row;
        int       oe_len;
        bit       last;
    } exp_t;

    exp_t        row_q[$];
    logic [10:0] addr_q[$];
    int checks = 0;
    int errors = 0;
    int accept_cnt = 0;
    int fd_cnt = 0;
    int model_r = 0;
    int model_p = 0;
    int ready_mode = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic rgb_row_t plane_row(input int r, input int p);
        rgb_row_t    x;
        logic [23:0] t, b;
        for (int c = 0; c < NUM_COLS; c++) begin
            t = mem[r * NUM_COLS + c];
            b = mem[(r + ROW_ADDRS) * NUM_COLS + c];
            x.top[c] = {t[16+p], t[8+p], t[p]};
            x.bot[c] = {b[16+p], b[8+p], b[p]};
        end
        return x;
    endfunction

    task automatic push_rows(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.r      = model_r;
            e.p      = model_p;
            e.row    = plane_row(model_r, model_p);
            e.oe_len = OE_UNIT << model_p;
            e.last   = (model_r == ROW_ADDRS - 1) && (model_p == COLOUR_DEPTH - 1);
            row_q.push_back(e);
            for (int c = 0; c < NUM_COLS; c++) begin
                addr_q.push_back(11'(model_r * NUM_COLS + c));
                addr_q.push_back(11'((model_r + ROW_ADDRS) * NUM_COLS + c));
            end
            model_p++;
            if (model_p == COLOUR_DEPTH) begin
                model_p = 0;
                model_r = (model_r + 1) % ROW_ADDRS;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_row_valid"}, row_valid_out, 0);
        check({tag, "_oe_window"}, oe_window_out, 0);
        check({tag, "_ram_enable"}, ram_enable_out, 0);
        check({tag, "_frame_done"}, frame_done_out, 0);
        check({tag, "_ram_addr"}, ram_addr_out, 0);
        check({tag, "_row_address"}, row_address_out, 0);
        check({tag, "_row_out_zero"}, (row_out == '0), 1);
    endtask

    // Returns at the posedge on which accept_cnt has reached n (bounded).
    task automatic wait_accepts(input int n, input int limit);
        int t = 0;
        while (accept_cnt < n && t < limit) begin
            @(posedge clk_in);
            t++;
        end
        check("accept_wait", accept_cnt, n);
    endtask

    task automatic stop_before(input int k);
        wait_accepts(k, 40000);
        #1 enable_in = 1'b0;
    endtask

    task automatic finish_phase(input string tag, input int n_rows);
        bit quiet = 1'b1;
        wait_accepts(n_rows, 40000);
        repeat (600) @(negedge clk_in);
        repeat (100) begin
            @(negedge clk_in);
            if (ram_enable_out || row_valid_out || oe_window_out) quiet = 1'b0;
        end
        check({tag, "_idle_quiet"}, quiet, 1);
        check({tag, "_rows_left"}, row_q.size(), 0);
        check({tag, "_reads_left"}, addr_q.size(), 0);
    endtask

    // Ready driver: 0 = held low, 1 = held high, 2 = random.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            case (ready_mode)
                0:       row_ready_in = 1'b0;
                1:       row_ready_in = 1'b1;
                default: row_ready_in = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // RAM read scoreboard.
    initial begin
        forever begin
            @(negedge clk_in);
            if (ram_enable_out) begin
                if (addr_q.size() == 0) check("unexpected_read", ram_addr_out, 11'h7FF);
                else                    check("read_addr", ram_addr_out, addr_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (frame_done_out) fd_cnt++;
        end
    end

    // Row monitor: compares each accepted plane, then its address, pulse and OE width.
    initial begin : monitor
        exp_t e;
        int   w;
        forever begin
            @(negedge clk_in);
            if (n_reset_in && row_valid_out && row_ready_in) begin
                if (row_q.size() == 0) begin
                    check("unexpected_row", accept_cnt, -1);
                    accept_cnt++;
                end else begin
                    e = row_q.pop_front();
                    checks++;
                    if (row_out !== e.row) begin
                        errors++;
                        $display("FAIL row_r%0d_p%0d actual=%h required=%h", e.r, e.p, row_out, e.row);
                    end
                    accept_cnt++;
                    @(negedge clk_in);
                    check("valid_drop", row_valid_out, 0);
                    check("row_address", row_address_out, e.r);
                    check("frame_done", frame_done_out, e.last);
                    w = 0;
                    while (oe_window_out && w < 2000) begin
                        w++;
                        @(negedge clk_in);
                    end
                    check($sformatf("oe_width_p%0d", e.p), w, e.oe_len);
                end
            end
        end
    end

    initial begin
        #(50 * 95000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stimulus
        int       n;
        bit       stable;
        rgb_row_t snap;
        logic [3:0] snap_a;

        #10 n_reset_in = 1'b0;
        #100;
        check_zero("reset");
        @(negedge clk_in);
        n_reset_in = 1'b1;

        // Phase 1: solid red, ready high, stop before the accept of (3,2).
        for (int i = 0; i < 2048; i++) mem[i] = 24'hFF0000;
        model_r = 0; model_p = 0;
        push_rows(27);
        accept_cnt = 0; fd_cnt = 0;
        ready_mode = 1;
        repeat (2) @(negedge clk_in);
        enable_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!row_valid_out && n < 400);
        check("first_valid_cycle", n, 130);
        check("red_plane_row", (row_out == {2 * NUM_COLS{3'b100}}), 1);
        stop_before(26);
        finish_phase("stop_r3p2", 27);
        check("phase1_frame_done", fd_cnt, 0);

        // Phase 2: random pixels, initial 50-cycle stall, random ready, full frame + wrap.
        for (int i = 0; i < 2048; i++) mem[i] = 24'($urandom);
        model_r = 0; model_p = 0;
        push_rows(131);
        accept_cnt = 0; fd_cnt = 0;
        ready_mode = 0;
        repeat (2) @(negedge clk_in);
        enable_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!row_valid_out && n < 400);
        check("restart_valid_cycle", n, 130);
        snap = row_out;
        snap_a = row_address_out;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk_in);
            if (row_out !== snap || !row_valid_out || ram_enable_out || row_address_out !== snap_a)
                stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        ready_mode = 2;
        stop_before(130);
        finish_phase("full_frame", 131);
        check("frame_done_pulses", fd_cnt, 1);

        // Phase 3: reset at fetch column 20, then a clean restart.
        model_r = 0; model_p = 0;
        push_rows(1);
        accept_cnt = 0;
        ready_mode = 1;
        @(negedge clk_in);
        enable_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!(ram_enable_out && ram_addr_out == 11'h014) && n < 400);
        check("reach_col20", (ram_enable_out && ram_addr_out == 11'h014), 1);
        #5 n_reset_in = 1'b0;
        #1 check_zero("mid_fetch_reset");
        enable_in = 1'b0;
        row_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk_in);
        check_zero("held_reset");
        n_reset_in = 1'b1;
        model_r = 0; model_p = 0;
        push_rows(1);
        accept_cnt = 0;
        @(negedge clk_in);
        enable_in = 1'b1;
        @(posedge clk_in);
        #1 enable_in = 1'b0;
        finish_phase("after_reset", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_display_frame_scheduler.md
LED_DISPLAY_FRAME_SCHEDULER -- requirements
Module: led_display_frame_scheduler

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- NUM_ROWS, 32, panel rows; the scan has NUM_ROWS/2 = 16 row addresses.
- NUM_COLS, 64, panel columns.
- COLOUR_DEPTH, 8, bits per colour channel, which is also the bit-plane count.
- OE_UNIT, 4, clk_in cycles of output-enable time for bit-plane 0.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_in, in, 1, display clock (20 MHz).
- n_reset_in, in, 1, reset; asynchronous, active-low.
- enable_in, in, 1, run request.
- ram_enable_out, out, 1, frame RAM read strobe.
- ram_addr_out, out, 11, frame RAM address {pixel_row[4:0], col[5:0]}.
- ram_data_in, in, 24, RAM read data {R[23:16], G[15:8], B[7:0]}, valid 1 cycle after the strobe.
- row_out, out, rgb_row_t, one bit-plane of a top/bottom row pair.
- row_valid_out, out, 1, row_out holds a row for the driver.
- row_ready_in, in, 1, driver accepts the row.
- row_address_out, out, 4, panel row address A..D.
- oe_window_out, out, 1, panel lit window for the accepted plane.
- frame_done_out, out, 1, single-cycle pulse at end of frame.

Function
REQ-003 The scan order SHALL nest plane p = 0..COLOUR_DEPTH-1 (inner) inside row address r = 0..15 (outer).
REQ-004 The FSM SHALL have states IDLE, FETCH, PRESENT and WAIT_OE.
REQ-005 IDLE -> FETCH SHALL occur when enable_in = 1, starting at r=0, p=0.
REQ-006 FETCH SHALL issue 128 consecutive reads in col order 0..63, top pixel (pixel_row r) then bottom pixel (pixel_row r+16), with ram_enable_out high for exactly 128 cycles.
REQ-007 For each read, bit p of R, G and B SHALL be captured 1 cycle later into row_out top[c] or bot[c] = {r,g,b}.
REQ-008 FETCH -> PRESENT SHALL occur one cycle after the last read returns (129 cycles in FETCH).
REQ-009 In PRESENT, row_valid_out SHALL be 1 and row_out SHALL be stable until the cycle with row_ready_in = 1 (the accept).
REQ-010 row_ready_in SHALL be ignored when row_valid_out = 0.
REQ-011 On accept: row_valid_out SHALL drop next cycle; row_address_out SHALL take r next cycle; oe_window_out SHALL go high for exactly OE_UNIT << p cycles.
REQ-012 After accept the next (r,p) SHALL advance and FETCH SHALL restart immediately, overlapping the OE window.
REQ-013 The next PRESENT SHALL NOT assert until oe_window_out = 0; the FSM SHALL wait in WAIT_OE if the fetch finishes first.
REQ-014 p SHALL wrap from 7 to 0 with r incrementing; r SHALL wrap from 15 to 0.
REQ-015 The accept of (r=15, p=7) SHALL produce a one-cycle frame_done_out pulse.
REQ-016 enable_in SHALL be sampled only in IDLE and at each accept; if it is 0 at an accept, the FSM SHALL go to IDLE after the OE window completes, and the next start SHALL be at r=0, p=0.
REQ-017 The OE counter SHALL be wide enough for OE_UNIT << (COLOUR_DEPTH-1) (512 cycles at defaults) without overflow.

Reset
REQ-018 On n_reset_in = 0 all outputs SHALL clear asynchronously: row_valid_out, oe_window_out, ram_enable_out and frame_done_out = 0; row_out = 0; ram_addr_out = 0; row_address_out = 0.
REQ-019 On reset the FSM SHALL return to IDLE with r = p = 0.
REQ-020 A reset mid-FETCH or mid-PRESENT SHALL discard the partial row.
REQ-021 Release SHALL take effect on the first clk_in edge with n_reset_in = 1.

Structure
REQ-022 rgb_row_t, NUM_ROWS, NUM_COLS and COLOUR_DEPTH SHALL reside in led_display_package.
REQ-023 The FSM state enum SHALL stay local to the module.
REQ-024 The OE window timer SHALL be one sub-module, led_display_oe_timer (load value in, busy out).
REQ-025 The block SHALL replace led_display_pattern_gen in the top level when frame display is selected.

Verification
REQ-026 Reset, then enable_in = 1 with a RAM model of 1-cycle latency and ready tied high -> first row_valid_out at cycle 130 after start; 128 strobes with addresses 0x000, 0x400, 0x001, ... 0x43F.
REQ-027 All pixels 0xFF0000 -> every plane has all top/bot = 3'b100; oe_window_out widths 4, 8, 16, ..., 512 cycles per row address.
REQ-028 row_ready_in held low for 50 cycles in PRESENT -> row_valid_out and row_out stable; no RAM reads; row_address_out unchanged.
REQ-029 Full frame with ready always high -> 128 accepts, row_address_out steps 0..15, exactly one frame_done_out pulse, then wrap to r=0, p=0.
REQ-030 Drop enable_in before the accept of (r=3, p=2) -> OE window of 16 cycles completes, then IDLE; re-enable restarts at r=0, p=0.
REQ-031 Assert n_reset_in = 0 at fetch column 20 -> all outputs 0 in the same cycle; after release and enable, a clean restart at address 0x000.
